// File: rtl/pitch_shifter_mc_pkg.sv
// Shared widths, helpers and the stage-1 pipeline entry for the multi-channel pitch shifter.
package pitch_shifter_mc_pkg;

    localparam int unsigned PS_DATA_WIDTH = 16;
    localparam int unsigned PS_CHANNELS   = 2;
    localparam int unsigned PS_FRAC_BITS  = 4;
    localparam int unsigned PS_FRAME_W    = PS_DATA_WIDTH * PS_CHANNELS;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned phase_w(input int unsigned depth, input int unsigned frac_bits);
        return addr_w(depth) + frac_bits;
    endfunction

    function automatic int unsigned step_unity(input int unsigned frac_bits);
        return 32'd1 << frac_bits;
    endfunction

    localparam int unsigned STEP_UNITY = step_unity(PS_FRAC_BITS);

    // Control travelling alongside the RAM read, plus the raw frame for bypass.
    typedef struct packed {
        logic                  valid;
        logic                  bypass;
        logic                  primed;
        logic                  swap;
        logic [PS_FRAME_W-1:0] data;
    } s1_entry_t;

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank frame store: one write port and one registered read port, each with bank select.
module pingpong_ram
    import pitch_shifter_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic                       wr_bank,
    input  logic [addr_w(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       rd_bank,
    input  logic [addr_w(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem [2*DEPTH];

    // Bank select is the MSB of the flat address; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/pitch_shifter_mc.sv
// Ping/pong block pitch shifter: writes blocks linearly, replays the previous block
// through a fractional phase accumulator whose step is latched at each bank swap.
module pitch_shifter_mc
    import pitch_shifter_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PS_DATA_WIDTH,
    parameter int unsigned CHANNELS   = PS_CHANNELS,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned FRAC_BITS  = PS_FRAC_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FRAC_BITS+1:0]           i_step,
    input  logic                           i_bypass,
    input  logic                           i_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    output logic                           o_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic                           o_swap
);

    localparam int unsigned ADDR_W  = addr_w(DEPTH);
    localparam int unsigned PHASE_W = phase_w(DEPTH, FRAC_BITS);
    localparam int unsigned STEP_W  = FRAC_BITS + 2;
    localparam int unsigned FRAME_W = CHANNELS * DATA_WIDTH;

    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_bank;
    logic [PHASE_W-1:0] rd_phase;
    logic [STEP_W-1:0]  step_act;
    logic               primed;
    logic               pend_swap;
    logic               swap_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [FRAME_W-1:0] rd_data;
    s1_entry_t          s1;

    assign swap_c    = i_valid && (wr_addr == ADDR_W'(DEPTH - 1));
    assign rd_addr_c = rd_phase[PHASE_W-1:FRAC_BITS];

    pingpong_ram #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (i_valid),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (i_data),
        .rd_en   (i_valid),
        .rd_bank (~wr_bank),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    // Pointer and block control; the swap overrides the phase increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr   <= '0;
            wr_bank   <= 1'b0;
            rd_phase  <= '0;
            step_act  <= STEP_W'(step_unity(FRAC_BITS));
            primed    <= 1'b0;
            pend_swap <= 1'b0;
        end else if (i_valid) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (swap_c) begin
                wr_bank   <= ~wr_bank;
                rd_phase  <= '0;
                step_act  <= i_step;
                primed    <= 1'b1;
                pend_swap <= 1'b1;
            end else begin
                rd_phase  <= rd_phase + PHASE_W'(step_act);
                pend_swap <= 1'b0;
            end
        end
    end

    // Stage 1 runs in parallel with the registered RAM read; stage 2 selects the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            o_valid <= 1'b0;
            o_swap  <= 1'b0;
            o_data  <= '0;
        end else begin
            s1 <= '{valid:  i_valid,
                    bypass: i_bypass,
                    primed: primed,
                    swap:   i_valid && pend_swap,
                    data:   PS_FRAME_W'(i_data)};
            o_valid <= s1.valid;
            o_swap  <= s1.valid && s1.swap;
            if (s1.valid) begin
                if (!s1.primed) begin
                    o_data <= '0;
                end else if (s1.bypass) begin
                    o_data <= FRAME_W'(s1.data);
                end else begin
                    o_data <= rd_data;
                end
            end
        end
    end

endmodule

// File: doc/pitch_shifter_mc.md
Name: pitch_shifter_mc

Overview:
Multi-channel, variable-ratio pitch shifter for the sigma-delta audio hardware test path.
- Incoming frames are written into a double-buffered (ping/pong) block RAM, one bank per block of DEPTH frames.
- The completed bank is read back with a fractional phase accumulator, so playback speed (pitch) is set by a programmable step rather than fixed up/down modes.
- Sits between the decimated ADC output and the DAC modulator input. Output rate equals input rate.

Parameters:
DATA_WIDTH, 16, bits per channel sample
CHANNELS, 2, channels per frame, packed channel 0 in LSBs
DEPTH, 256, frames per bank; power of two, >= 4
FRAC_BITS, 4, fractional bits of step and read phase

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high; one clock; polarity and synchronicity fixed
i_step  in  FRAC_BITS+2  playback ratio, unsigned Q2.FRAC_BITS; 1<<FRAC_BITS = unity
i_bypass  in  1  1 = pass input through, delayed only by the pipeline
i_valid  in  1  frame strobe, one frame per asserted cycle, any spacing
i_data  in  CHANNELS*DATA_WIDTH  input frame
o_valid  out  1  output frame strobe
o_data  out  CHANNELS*DATA_WIDTH  output frame
o_swap  out  1  one-cycle pulse aligned with o_valid of the first frame read from a new bank

Behaviour:
- ADDR_W = $clog2(DEPTH). State:
  - wr_addr, ADDR_W bits
  - wr_bank, 1 bit
  - rd_phase, ADDR_W+FRAC_BITS bits
  - step_act, FRAC_BITS+2 bits
  - primed, 1 bit
- Reset values:
  - wr_addr = 0, wr_bank = 0, rd_phase = 0, primed = 0.
  - step_act = 1<<FRAC_BITS.
  - o_valid = 0, o_data = 0, o_swap = 0.
  - Pipeline valids are cleared, so in-flight frames are discarded. RAM contents are not cleared.
- Per i_valid cycle:
  - Write i_data to bank wr_bank at wr_addr, then wr_addr += 1 (mod DEPTH).
  - Read bank ~wr_bank at rd_addr = rd_phase[ADDR_W+FRAC_BITS-1:FRAC_BITS].
  - rd_phase += step_act, wrapping mod DEPTH<<FRAC_BITS, so the read wraps within the bank.
- Bank swap, when i_valid and wr_addr == DEPTH-1:
  - wr_bank toggles.
  - rd_phase <= 0, overriding the increment.
  - step_act <= i_step.
  - primed <= 1.
  - The read issued in the swap cycle still uses the old bank and old phase.
- i_step is sampled only at a swap. Changes mid-block have no effect until the next swap, which keeps ratio changes glitch-free per block.
- Latency: i_valid at cycle N gives o_valid at N+2, with no exceptions.
  - Stage 1 is the registered RAM read.
  - Stage 2 is the output mux/register.
- o_valid is high exactly one cycle per accepted i_valid, including during bypass and before priming.
- o_data value:
  - While primed == 0 at the read cycle: o_data = 0.
  - i_bypass sampled at cycle N = 1: o_data = the i_data of cycle N. RAM writes and pointer updates continue unchanged, so leaving bypass is seamless.
- o_swap = 1 with the o_valid of the first read after each swap, i.e. the read with rd_phase = 0 in the new bank.
- Step boundary cases:
  - step 0: the same frame repeats for the whole block.
  - Maximum step ((4<<FRAC_BITS)-1): wraps the read bank multiple times per block. This is legal.
- Channels share all pointers. Each channel lane is an independent DATA_WIDTH slice, with no cross-lane arithmetic.
- i_valid with no gaps at full clock rate is supported. Read and write never target the same bank in the same cycle.

Decomposition:
- Package pitch_shifter_mc_pkg holds:
  - functions addr_w(DEPTH) and phase_w(DEPTH, FRAC_BITS)
  - constant localparam STEP_UNITY helper
  - typedef struct for the stage-1 pipeline entry (valid, bypass, primed, swap, bypass data)
- Sub-module pingpong_ram holds the two banks:
  - 1 write port with bank select
  - 1 registered read port with bank select
  - width CHANNELS*DATA_WIDTH, depth DEPTH
  - The top level holds pointers, control and the output stage.

Test Plan:
- Unity: DEPTH=8, CHANNELS=2, step=16 (FRAC_BITS=4), ramp input with ch0 = k and ch1 = 1000+k for k = 0..31.
  - Outputs for k < 8 are 0.
  - Output frame k (k >= 8) = input frame k-8.
  - o_swap is high on outputs 8, 16 and 24.
  - Each o_valid occurs 2 cycles after its i_valid.
- Octave up: step=32, after priming.
  - Output sequence within a block is bank[0], bank[2], bank[4], bank[6], bank[0], bank[2], bank[4], bank[6].
- Half speed: step=8.
  - Output sequence within a block is bank[0], bank[0], bank[1], bank[1], ..., bank[3], bank[3].
- Step change mid-block: i_step changes 16 to 32 at write index 3.
  - The current block's output is unaffected.
  - The new ratio applies starting with the o_swap frame.
- Bypass toggled mid-stream, with i_valid on every cycle.
  - o_data = i_data delayed 2 cycles while bypass is high.
  - The shifted output resumes at the correct block phase without a hiccup.
- Reset mid-block at write index 5.
  - The next two cycles have o_valid = 0.
  - Afterwards o_data is 0 for the next DEPTH frames, then the unity delay resumes from the fresh block.
